// File: rtl/data_burst_controller_pkg.sv
// Shared types and sizing for the data burst controller.
// Imported by the splitter and the top-level FSM.
package data_burst_controller_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 9;
  localparam int BANK_DEPTH = 256;
  localparam int PTR_W      = $clog2(BANK_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_CMD,
    RD_DATA,
    GAP,
    DONE
  } state_t;

  // A zero burst limit still has to make progress.
  function automatic logic [DATA_W-1:0] eff_max(
    input logic [DATA_W-1:0] m
  );
    return (m == '0) ? DATA_W'(1) : m;
  endfunction

endpackage

// File: rtl/burst_splitter.sv
// Sizes the next burst: beats = min(remaining, limit),
// and what is left once that burst has completed.
module burst_splitter
  import data_burst_controller_pkg::*;
(
  input  logic [DATA_W-1:0] remaining,
  input  logic [DATA_W-1:0] max_burst,
  output logic [DATA_W-1:0] beats,
  output logic [DATA_W-1:0] rest
);

  logic [DATA_W-1:0] lim;

  always_comb begin
    lim   = eff_max(max_burst);
    beats = (remaining < lim) ? remaining : lim;
    rest  = remaining - beats;
  end

endmodule

// File: rtl/data_burst_controller.sv
// Moves bytes between the register bank and a burst bus,
// splitting a transfer into bursts of bounded length.
module data_burst_controller
  import data_burst_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rb_db_start,
  input  logic [DATA_W-1:0] rb_db_length,
  input  logic [DATA_W-1:0] rb_db_max_burst_size,
  input  logic              rb_db_rw,
  input  logic [DATA_W-1:0] rb_db_data,
  input  logic              rb_db_ack,
  output logic              db_rb_req,
  output logic [ADDR_W-1:0] db_rb_addr,
  output logic [DATA_W-1:0] db_rb_data,
  output logic              db_rb_rd_done,
  output logic              db_rb_idle,
  output logic              db_bs_valid,
  output logic              db_bs_rw,
  output logic [DATA_W-1:0] db_bs_len,
  output logic              db_bs_first,
  output logic              db_bs_last,
  output logic [DATA_W-1:0] db_bs_wdata,
  input  logic              bs_db_ready,
  input  logic              bs_db_rvalid,
  input  logic [DATA_W-1:0] bs_db_rdata
);

  state_t st, nxt;

  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] remaining;
  logic [DATA_W-1:0] max_q;
  logic              rw_q;
  logic [DATA_W-1:0] cur_len;
  logic [DATA_W-1:0] beat_cnt;
  logic              last_burst;

  logic              capture;
  logic              load;
  logic              beat;
  logic              last_beat;

  logic [DATA_W-1:0] sp_rem;
  logic [DATA_W-1:0] sp_max;
  logic [DATA_W-1:0] sp_beats;
  logic [DATA_W-1:0] sp_rest;

  // The first burst is sized straight from the start inputs.
  assign sp_rem = (st == IDLE) ? rb_db_length : remaining;
  assign sp_max = (st == IDLE) ? rb_db_max_burst_size : max_q;

  burst_splitter u_split (
    .remaining (sp_rem),
    .max_burst (sp_max),
    .beats     (sp_beats),
    .rest      (sp_rest)
  );

  assign last_beat = (beat_cnt == cur_len - DATA_W'(1));

  always_comb begin
    nxt           = st;
    capture       = 1'b0;
    load          = 1'b0;
    beat          = 1'b0;
    db_rb_req     = 1'b0;
    db_rb_addr    = '0;
    db_rb_data    = '0;
    db_rb_rd_done = 1'b0;
    db_rb_idle    = 1'b0;
    db_bs_valid   = 1'b0;
    db_bs_rw      = 1'b0;
    db_bs_len     = '0;
    db_bs_first   = 1'b0;
    db_bs_last    = 1'b0;
    db_bs_wdata   = '0;
    unique case (st)
      IDLE: begin
        db_rb_idle = 1'b1;
        if (rb_db_start) begin
          capture = 1'b1;
          load    = 1'b1;
          if (rb_db_length == '0) nxt = DONE;
          else if (rb_db_rw)      nxt = WR_DATA;
          else                    nxt = RD_CMD;
        end
      end
      WR_DATA: begin
        db_bs_valid = 1'b1;
        db_bs_rw    = 1'b1;
        db_bs_len   = cur_len;
        db_bs_first = (beat_cnt == '0);
        db_bs_last  = last_beat;
        db_bs_wdata = rb_db_data;
        db_rb_req   = 1'b1;
        db_rb_addr  = {1'b0, ptr};
        if (bs_db_ready) begin
          beat = 1'b1;
          if (last_beat) nxt = last_burst ? DONE : GAP;
        end
      end
      RD_CMD: begin
        db_bs_valid = 1'b1;
        db_bs_len   = cur_len;
        db_bs_first = 1'b1;
        if (bs_db_ready) nxt = RD_DATA;
      end
      RD_DATA: begin
        db_bs_len = cur_len;
        if (bs_db_rvalid) begin
          db_rb_req  = 1'b1;
          db_rb_addr = {1'b0, ptr};
          db_rb_data = bs_db_rdata;
          db_bs_last = last_beat;
          beat       = 1'b1;
          if (last_beat) nxt = last_burst ? DONE : GAP;
        end
      end
      GAP: begin
        load = 1'b1;
        nxt  = rw_q ? WR_DATA : RD_CMD;
      end
      DONE: begin
        db_rb_rd_done = ~rw_q;
        nxt           = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      max_q      <= '0;
      rw_q       <= 1'b0;
      cur_len    <= '0;
      beat_cnt   <= '0;
      last_burst <= 1'b0;
    end else begin
      st <= nxt;
      if (capture) begin
        remaining <= rb_db_length;
        max_q     <= rb_db_max_burst_size;
        rw_q      <= rb_db_rw;
        ptr       <= '0;
      end
      if (load) begin
        cur_len    <= sp_beats;
        last_burst <= (sp_rest == '0);
        beat_cnt   <= '0;
      end
      if (beat) begin
        ptr       <= ptr + PTR_W'(1);
        remaining <= remaining - DATA_W'(1);
        beat_cnt  <= beat_cnt + DATA_W'(1);
      end
    end
  end

  // Read beats have no retry path, so an unaccepted one is lost.
  always @(posedge clk) begin
    if (rst_n && st == RD_DATA && bs_db_rvalid)
      rd_ack_chk: assert (rb_db_ack);
    if (rst_n && beat)
      ptr_wrap_chk: assert (ptr != '1);
  end

endmodule

// File: tb/tb_data_burst_controller.sv
// Scoreboard bench: stimulus queues expected bus/bank events,
// a negedge monitor pops and compares each observed event.
module tb_data_burst_controller;
  import data_burst_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rb_db_start = 1'b0;
  logic [7:0] rb_db_length = '0;
  logic [7:0] rb_db_max_burst_size = '0;
  logic       rb_db_rw = 1'b0;
  logic [7:0] rb_db_data;
  logic       rb_db_ack;
  logic       db_rb_req;
  logic [8:0] db_rb_addr;
  logic [7:0] db_rb_data;
  logic       db_rb_rd_done;
  logic       db_rb_idle;
  logic       db_bs_valid;
  logic       db_bs_rw;
  logic [7:0] db_bs_len;
  logic       db_bs_first;
  logic       db_bs_last;
  logic [7:0] db_bs_wdata;
  logic       bs_db_ready = 1'b1;
  logic       bs_db_rvalid = 1'b0;
  logic [7:0] bs_db_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_burst_controller dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rb_db_start          (rb_db_start),
    .rb_db_length         (rb_db_length),
    .rb_db_max_burst_size (rb_db_max_burst_size),
    .rb_db_rw             (rb_db_rw),
    .rb_db_data           (rb_db_data),
    .rb_db_ack            (rb_db_ack),
    .db_rb_req            (db_rb_req),
    .db_rb_addr           (db_rb_addr),
    .db_rb_data           (db_rb_data),
    .db_rb_rd_done        (db_rb_rd_done),
    .db_rb_idle           (db_rb_idle),
    .db_bs_valid          (db_bs_valid),
    .db_bs_rw             (db_bs_rw),
    .db_bs_len            (db_bs_len),
    .db_bs_first          (db_bs_first),
    .db_bs_last           (db_bs_last),
    .db_bs_wdata          (db_bs_wdata),
    .bs_db_ready          (bs_db_ready),
    .bs_db_rvalid         (bs_db_rvalid),
    .bs_db_rdata          (bs_db_rdata)
  );

  function automatic logic [7:0] bank_val(input int a);
    return 8'((a * 7 + 'h31) & 'hff);
  endfunction

  assign rb_db_data = bank_val(int'(db_rb_addr));
  assign rb_db_ack  = 1'b1;

  localparam logic [1:0] K_W = 2'd0;
  localparam logic [1:0] K_C = 2'd1;
  localparam logic [1:0] K_R = 2'd2;
  localparam logic [1:0] K_D = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [8:0] addr;
    logic [7:0] data;
    logic [7:0] len;
    logic       first;
    logic       last;
  } ev_t;

  ev_t exp_q[$];

  function automatic ev_t mk(input logic [1:0] k, input int a,
                             input int d, input int l,
                             input bit f, input bit la);
    ev_t e;
    e.kind  = k;
    e.addr  = 9'(a);
    e.data  = 8'(d);
    e.len   = 8'(l);
    e.first = f;
    e.last  = la;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: one event per cycle, plus write hold-stability.
  ev_t act;
  ev_t exp_e;
  bit has_ev;
  bit prev_stall = 1'b0;
  logic [34:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ({db_bs_valid, db_rb_addr, db_bs_wdata, db_bs_len,
             db_bs_first, db_bs_last, db_bs_rw} !== held) begin
          errors++;
          $display("FAIL hold_stable: got %h expected %h",
                   {db_bs_valid, db_rb_addr, db_bs_wdata, db_bs_len,
                    db_bs_first, db_bs_last, db_bs_rw}, held);
        end
      end
      prev_stall = db_bs_valid && db_bs_rw && !bs_db_ready;
      held = {db_bs_valid, db_rb_addr, db_bs_wdata, db_bs_len,
              db_bs_first, db_bs_last, db_bs_rw};
      has_ev = 1'b1;
      if (db_bs_valid && bs_db_ready && db_bs_rw)
        act = mk(K_W, int'(db_rb_addr), int'(db_bs_wdata),
                 int'(db_bs_len), db_bs_first, db_bs_last);
      else if (db_bs_valid && bs_db_ready)
        act = mk(K_C, int'(db_rb_addr), int'(db_rb_data),
                 int'(db_bs_len), db_bs_first, db_bs_last);
      else if (!db_bs_valid && db_rb_req)
        act = mk(K_R, int'(db_rb_addr), int'(db_rb_data),
                 int'(db_bs_len), db_bs_first, db_bs_last);
      else if (db_rb_rd_done)
        act = mk(K_D, 0, 0, 0, 1'b0, 1'b0);
      else
        has_ev = 1'b0;
      if (has_ev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h expected none", act);
        end else begin
          exp_e = exp_q.pop_front();
          if (act !== exp_e) begin
            errors++;
            $display("FAIL event: got %h expected %h", act, exp_e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int len, input int mx, input bit rw);
    rb_db_start          = 1'b1;
    rb_db_length         = 8'(len);
    rb_db_max_burst_size = 8'(mx);
    rb_db_rw             = rw;
    tick();
    rb_db_start = 1'b0;
  endtask

  task automatic push_write(input int len, input int mx);
    int p = 0;
    int m = (mx == 0) ? 1 : mx;
    while (p < len) begin
      int b = (len - p < m) ? len - p : m;
      for (int k = 0; k < b; k++) begin
        exp_q.push_back(mk(K_W, p, int'(bank_val(p)), b,
                           k == 0, k == b - 1));
        p++;
      end
    end
  endtask

  // Runs to IDLE; optionally toggles ready and re-pulses start.
  task automatic wait_idle(input bit toggle, input int pulse_at,
                           input int exp_busy, input string name);
    int busy = 0;
    while (!db_rb_idle && busy < 200) begin
      bs_db_ready = toggle ? 1'(busy % 2) : 1'b1;
      if (busy == pulse_at) begin
        rb_db_start          = 1'b1;
        rb_db_length         = 8'd9;
        rb_db_max_burst_size = 8'd1;
        rb_db_rw             = 1'b0;
      end else begin
        rb_db_start = 1'b0;
      end
      busy++;
      tick();
    end
    rb_db_start = 1'b0;
    bs_db_ready = 1'b1;
    check(name, busy, exp_busy);
  endtask

  // Acts as the burst slave for a read; stop_after aborts early.
  task automatic do_read(input int len, input int mx, input int base,
                         input int stop_after);
    int sent = 0;
    int m = (mx == 0) ? 1 : mx;
    start_xfer(len, mx, 1'b0);
    while (sent < len) begin
      int b = (len - sent < m) ? len - sent : m;
      int n = 0;
      exp_q.push_back(mk(K_C, 0, 0, b, 1'b1, 1'b0));
      while (!(db_bs_valid && !db_bs_rw) && n < 20) begin
        tick();
        n++;
      end
      if (n == 20) begin
        checks++;
        errors++;
        $display("FAIL rd_cmd_timeout: got none expected RD_CMD");
        return;
      end
      tick();
      for (int k = 0; k < b; k++) begin
        exp_q.push_back(mk(K_R, sent, base + sent, b, 1'b0, k == b - 1));
        bs_db_rvalid = 1'b1;
        bs_db_rdata  = 8'(base + sent);
        tick();
        sent++;
        if (sent == stop_after) begin
          bs_db_rvalid = 1'b0;
          return;
        end
      end
      bs_db_rvalid = 1'b0;
    end
    exp_q.push_back(mk(K_D, 0, 0, 0, 1'b0, 1'b0));
  endtask

  function automatic int outs_nonidle();
    return int'({db_rb_req, db_rb_addr, db_rb_data, db_rb_rd_done,
                 db_bs_valid, db_bs_rw, db_bs_len, db_bs_first,
                 db_bs_last, db_bs_wdata} != '0);
  endfunction

  initial begin
    #2;
    check("reset_idle", int'(db_rb_idle), 1);
    check("reset_outs", outs_nonidle(), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write 5 bytes, bursts of 2: 2+2+1 beats, two gaps.
    push_write(5, 2);
    start_xfer(5, 2, 1'b1);
    wait_idle(1'b0, -1, 8, "wr5_busy");
    check("wr5_idle", int'(db_rb_idle), 1);

    // Read 4 bytes in one burst.
    do_read(4, 4, 'hA0, -1);
    wait_idle(1'b0, -1, 1, "rd4_done_len");

    // Zero length: straight to DONE with no activity.
    start_xfer(0, 4, 1'b1);
    @(negedge clk);
    check("len0_busy", int'(db_rb_idle), 0);
    check("len0_valid", int'(db_bs_valid), 0);
    check("len0_req", int'(db_rb_req), 0);
    #1;
    wait_idle(1'b0, -1, 1, "len0_cycles");

    // Zero max burst with ready toggling.
    push_write(3, 0);
    start_xfer(3, 0, 1'b1);
    wait_idle(1'b1, -1, 7, "wr3_busy");

    // Start pulse mid-transfer is ignored.
    push_write(4, 3);
    start_xfer(4, 3, 1'b1);
    wait_idle(1'b0, 1, 6, "wr4_busy");

    // Reset in the middle of a read.
    do_read(6, 4, 'h50, 2);
    rst_n = 1'b0;
    #1;
    check("abort_idle", int'(db_rb_idle), 1);
    check("abort_outs", outs_nonidle(), 0);
    check("abort_q", exp_q.size(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", int'(db_rb_idle), 1);

    do_read(6, 4, 'h60, -1);
    wait_idle(1'b0, -1, 1, "rd6_done_len");

    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/data_burst_controller.md
DATA_BURST_CONTROLLER -- requirements
Module: data_burst_controller

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock, rising edge) and rst_n (in, 1, asynchronous active-low reset); one clock, reset asynchronous and active-low.
REQ-002 SHALL have rb_db_start (in, 1): transfer start pulse from the register bank.
REQ-003 SHALL have rb_db_length (in, 8): bytes to transfer. rb_db_max_burst_size (in, 8): beat limit per burst. rb_db_rw (in, 1): 1 = bank-to-burst write, 0 = burst-to-bank read.
REQ-004 SHALL have rb_db_data (in, 8): bank data for the address on db_rb_addr, valid in the same cycle as db_rb_req. rb_db_ack (in, 1): bank access accepted.
REQ-005 SHALL have db_rb_req (out, 1), db_rb_addr (out, 9) and db_rb_data (out, 8) for bank access; db_rb_rd_done (out, 1) for read completion; db_rb_idle (out, 1) for controller idle.
REQ-006 SHALL have db_bs_valid (out, 1), db_bs_rw (out, 1), db_bs_len (out, 8, beats in current burst), db_bs_first (out, 1), db_bs_last (out, 1) and db_bs_wdata (out, 8) toward the burst interface.
REQ-007 SHALL have bs_db_ready (in, 1), bs_db_rvalid (in, 1) and bs_db_rdata (in, 8) from the burst interface.

Function
REQ-008 SHALL implement states IDLE, WR_DATA, RD_CMD, RD_DATA, GAP and DONE.
REQ-009 In IDLE with rb_db_start=1, SHALL capture length, max_burst_size and rw, clear ptr to 0, and move to WR_DATA (rw=1) or RD_CMD (rw=0) on the next edge; db_rb_idle=1 only in IDLE.
REQ-010 rb_db_start SHALL be ignored outside IDLE.
REQ-011 Captured length 0 SHALL go IDLE->DONE with no burst or bank activity.
REQ-012 Captured max_burst_size 0 SHALL be treated as 1.
REQ-013 Burst beats SHALL be min(remaining, max_burst), presented on db_bs_len for the whole burst.
REQ-014 WR_DATA: db_bs_valid=1, db_bs_rw=1, db_rb_req=1, db_rb_addr={1'b0,ptr}, db_bs_wdata=rb_db_data (combinational).
REQ-015 WR_DATA: a beat completes on valid&ready; ptr increments and remaining decrements; outputs SHALL hold stable while ready=0.
REQ-016 RD_CMD: db_bs_valid=1, db_bs_rw=0, db_bs_first=1; on ready, SHALL move to RD_DATA.
REQ-017 RD_DATA: each bs_db_rvalid SHALL drive db_rb_req=1, db_rb_addr={1'b0,ptr}, db_rb_data=bs_db_rdata in the same cycle, then increment ptr. bs_db_rvalid outside RD_DATA SHALL be ignored.
REQ-018 db_bs_first SHALL be 1 on the first beat of each write burst; db_bs_last SHALL be 1 on the final beat of each burst.
REQ-019 After a burst's last beat: remaining>0 SHALL go to GAP (one cycle, all bus outputs 0), then WR_DATA or RD_CMD; remaining=0 SHALL go to DONE.
REQ-020 DONE SHALL last one cycle, then go to IDLE; db_rb_rd_done=1 in DONE only for read transfers.
REQ-021 ptr SHALL be 8 bits, SHALL never wrap within a transfer (max 255 bytes), and db_rb_addr SHALL never reach 256.
REQ-022 A read beat in which rb_db_ack=0 SHALL be flagged by an assertion; no retry.

Reset
REQ-023 rst_n low SHALL force IDLE at once, including mid-transfer, with ptr, remaining and beat counters cleared.
REQ-024 During reset SHALL hold db_rb_idle=1 and every other output at 0; a partial transfer SHALL be abandoned without db_rb_rd_done.

Structure
REQ-025 A shared package SHALL hold the state enum, DATA_W=8, ADDR_W=9 and BANK_DEPTH=256.
REQ-026 A sub-module burst_splitter SHALL compute next burst beats and remaining from remaining and max_burst (pure combinational); the FSM and counters SHALL stay in the top.

Verification
REQ-027 Write, length=5, max=2, ready always 1: bursts of 2, 2, 1 beats; wdata = bank[0..4]; one GAP cycle between bursts; db_rb_idle returns 1 after DONE.
REQ-028 Read, length=4, max=4, rdata 0xA0..0xA3: one RD_CMD, bank[0..3]=A0..A3, db_rb_rd_done high exactly one cycle.
REQ-029 length=0, start: IDLE->DONE->IDLE; no db_bs_valid or db_rb_req asserted.
REQ-030 Write, length=3, max=0, ready toggling 1/0: three 1-beat bursts with first=last=1; data held stable across ready=0.
REQ-031 Read, length=6, max=4: rst_n asserted after beat 2 -> all outputs reset at once, no rd_done; a new start after reset completes normally.
REQ-032 rb_db_start pulsed mid-transfer: ignored; byte count and addresses unchanged.
